aes_mode_engine: RTL and testbench

Streaming AES-128 encryption engine that wraps the existing `aes_cipher` core and adds ECB, CBC and CTR modes of operation, valid/ready block streaming and a buffered output. It is the parametrised successor to the fixed-vector top-level cipher wrapper. It sits between a bus-side DMA/register front end and the `aes_cipher` core, and handles key/IV configuration, chaining state and back-pressure so the front end only moves 128-bit blocks.

---
 rtl/aes_mode_pkg.sv | 29 ++
 rtl/aes_blk_fifo.sv | 57 +++++
 rtl/aes_cipher.sv | 117 +++++++++++
 rtl/aes_mode_engine.sv | 148 ++++++++++++++
 tb/tb_aes_mode_engine.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_mode_pkg.sv
// Shared definitions for the AES mode engine.
//   - AES_BLK_W     : cipher block width
//   - MODE_*        : cfg_mode encodings (2'b11 is reserved and runs as ECB)
//   - state_e       : engine control FSM states
//   - ctr_inc       : CTR counter-block increment limited to the low w bits
package aes_mode_pkg;

  localparam int AES_BLK_W = 128;

  localparam logic [1:0] MODE_ECB = 2'b00;
  localparam logic [1:0] MODE_CBC = 2'b01;
  localparam logic [1:0] MODE_CTR = 2'b10;

  typedef enum logic [1:0] {
    ST_UNCFG = 2'b00,
    ST_READY = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

  // Adds one to the low w bits modulo 2^w; bits above w are passed through.
  function automatic logic [AES_BLK_W-1:0] ctr_inc(input logic [AES_BLK_W-1:0] c,
                                                    input int unsigned w);
    logic [AES_BLK_W-1:0] mask;
    if (w >= 32'd128) mask = '1;
    else              mask = (128'd1 << w) - 128'd1;
    return (c & ~mask) | ((c + 128'd1) & mask);
  endfunction

endpackage

// File: rtl/aes_blk_fifo.sv
// Synchronous block FIFO with show-ahead head and occupancy count.
// Ports: clk, rst (async active-low), push/push_data (write), pop (read),
//        head (current oldest entry, 0 when empty), count, empty.
// A push while full is accepted only when a pop happens in the same cycle.
module aes_blk_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   cnt_r;
  logic          wr_s;
  logic          rd_s;

  assign empty = (cnt_r == '0);
  assign rd_s  = pop && !empty;
  assign wr_s  = push && ((cnt_r != DEPTH_C) || rd_s);
  assign head  = empty ? '0 : mem_r[rd_ptr_r];
  assign count = cnt_r;

  // Entry storage; contents need no reset because head is gated by empty.
  always_ff @(posedge clk) begin
    if (wr_s) mem_r[wr_ptr_r] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (wr_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (rd_s) rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({wr_s, rd_s})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES-128 encryption core, one round per clock.
// Ports: clk, rst (async active-low), ld (start, samples key/text_in),
//        done (one-cycle pulse when text_out is updated), key, text_in, text_out.
// Round keys are expanded on the fly alongside the data rounds.
module aes_cipher (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  output logic         done,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      v = gf_mul(v, v);
      if (i != 0) v = gf_mul(v, x);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte 4*c+r of the block is state row r, column c.
  function automatic logic [127:0] enc_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   s [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = b[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o ^ rk;
  endfunction

  logic [127:0] st_r;
  logic [127:0] rk_r;
  logic [7:0]   rcon_r;
  logic [3:0]   rnd_r;
  logic         run_r;
  logic [127:0] rk_next_s;
  logic [127:0] round_s;

  assign rk_next_s = next_key(rk_r, rcon_r);
  assign round_s   = enc_round(st_r, rk_next_s, rnd_r == 4'd10);

  // Round sequencer: initial AddRoundKey on ld, then rounds 1..10.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_r     <= '0;
      rk_r     <= '0;
      rcon_r   <= 8'h00;
      rnd_r    <= 4'd0;
      run_r    <= 1'b0;
      done     <= 1'b0;
      text_out <= '0;
    end else begin
      done <= 1'b0;
      if (ld) begin
        st_r   <= text_in ^ key;
        rk_r   <= key;
        rcon_r <= 8'h01;
        rnd_r  <= 4'd1;
        run_r  <= 1'b1;
      end else if (run_r) begin
        st_r   <= round_s;
        rk_r   <= rk_next_s;
        rcon_r <= xtime(rcon_r);
        rnd_r  <= rnd_r + 4'd1;
        if (rnd_r == 4'd10) begin
          run_r    <= 1'b0;
          done     <= 1'b1;
          text_out <= round_s;
        end
      end
    end
  end

endmodule

// File: rtl/aes_mode_engine.sv
// Streaming AES-128 engine: ECB / CBC / CTR around a single aes_cipher core.
// Ports: clk, rst (async active-low)
//        cfg_ld/cfg_mode/cfg_key/cfg_iv : configuration strobe (ignored while busy)
//        busy                           : block in flight in the core
//        in_valid/in_ready/in_data      : plaintext block stream
//        out_valid/out_ready/out_data   : ciphertext stream from the output FIFO
//        blk_cnt                        : blocks pushed since the last accepted cfg_ld
// One block is in flight at a time and input is only taken with a free FIFO
// slot, so the push at core done can never overflow the FIFO.
module aes_mode_engine
  import aes_mode_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int CTR_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_ld,
  input  logic [1:0]         cfg_mode,
  input  logic [127:0]       cfg_key,
  input  logic [127:0]       cfg_iv,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic [CNT_W-1:0]   blk_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  state_e                 state_r, state_s;
  logic [1:0]             mode_r;
  logic [AES_BLK_W-1:0]   key_r;
  logic [AES_BLK_W-1:0]   chain_r;     // CBC chaining value or CTR counter block
  logic [AES_BLK_W-1:0]   pending_r;   // CTR plaintext awaiting its keystream
  logic [AES_BLK_W-1:0]   text_r;
  logic                   ld_r;
  logic                   busy_r;
  logic [CNT_W-1:0]       blk_cnt_r;

  logic                   core_done_s;
  logic [AES_BLK_W-1:0]   core_out_s;
  logic [CW-1:0]          fifo_cnt_s;
  logic                   fifo_empty_s;
  logic                   hs_s;
  logic                   cfg_acc_s;
  logic                   push_s;
  logic                   pop_s;
  logic [AES_BLK_W-1:0]   text_s;
  logic [AES_BLK_W-1:0]   push_data_s;

  assign in_ready  = (state_r == ST_READY) && (fifo_cnt_s < DEPTH_C) && !cfg_ld;
  assign hs_s      = in_valid && in_ready;
  assign cfg_acc_s = cfg_ld && (state_r != ST_WAIT);
  assign push_s    = core_done_s && (state_r == ST_WAIT);
  assign pop_s     = out_valid && out_ready;
  assign out_valid = !fifo_empty_s;
  assign busy      = busy_r;
  assign blk_cnt   = blk_cnt_r;

  // Next-state decode for the control FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_UNCFG: if (cfg_ld)      state_s = ST_READY; else state_s = ST_UNCFG;
      ST_READY: if (hs_s)        state_s = ST_WAIT;  else state_s = ST_READY;
      ST_WAIT:  if (core_done_s) state_s = ST_READY; else state_s = ST_WAIT;
      default:                   state_s = ST_UNCFG;
    endcase
  end

  // Core operand and FIFO push value selection by mode; reserved mode runs as ECB.
  always_comb begin
    text_s      = in_data;
    push_data_s = core_out_s;
    case (mode_r)
      MODE_CBC: text_s = in_data ^ chain_r;
      MODE_CTR: begin
        text_s      = chain_r;
        push_data_s = core_out_s ^ pending_r;
      end
      default: text_s = in_data;
    endcase
  end

  // Control state, configuration, chaining and block counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_UNCFG;
      mode_r    <= MODE_ECB;
      key_r     <= '0;
      chain_r   <= '0;
      pending_r <= '0;
      text_r    <= '0;
      ld_r      <= 1'b0;
      busy_r    <= 1'b0;
      blk_cnt_r <= '0;
    end else begin
      state_r <= state_s;
      ld_r    <= hs_s;
      busy_r  <= (state_s == ST_WAIT);
      if (cfg_acc_s) begin
        key_r     <= cfg_key;
        mode_r    <= cfg_mode;
        chain_r   <= cfg_iv;
        blk_cnt_r <= '0;
      end else if (push_s) begin
        blk_cnt_r <= blk_cnt_r + 1'b1;
        if (mode_r == MODE_CBC) chain_r <= core_out_s;
        if (mode_r == MODE_CTR) chain_r <= ctr_inc(chain_r, CTR_W);
      end
      if (hs_s) begin
        text_r    <= text_s;
        pending_r <= in_data;
      end
    end
  end

  aes_cipher u_core (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld_r),
    .done     (core_done_s),
    .key      (key_r),
    .text_in  (text_r),
    .text_out (core_out_s)
  );

  aes_blk_fifo #(
    .W     (AES_BLK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (out_data),
    .count     (fifo_cnt_s),
    .empty     (fifo_empty_s)
  );

endmodule

// File: tb/tb_aes_mode_engine.sv
// Self-checking bench for aes_mode_engine: known-answer table, hand-written
// chaining / back-pressure / reset sequences, and random streams checked
// against a byte-matrix AES reference with plain mode arithmetic.
module tb_aes_mode_engine;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cfg_ld = 1'b0;
  logic [1:0]   cfg_mode = 2'b00;
  logic [127:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         busy;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [15:0]  blk_cnt;

  int           n_cmp = 0;
  int           n_err = 0;
  int           ready_mode = 1;   // 0 hold off, 1 always ready, 2 random
  logic [127:0] exp_q [$];
  logic [7:0]   sb [256];
  logic [1:0]   m_mode;
  logic [127:0] m_key;
  logic [127:0] m_chain;

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] key;
    logic [127:0] iv;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;
  vec_t tbl [5];

  aes_mode_engine #(.FIFO_DEPTH(4), .CNT_W(16), .CTR_W(32)) dut (
    .clk(clk), .rst(rst), .cfg_ld(cfg_ld), .cfg_mode(cfg_mode), .cfg_key(cfg_key),
    .cfg_iv(cfg_iv), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    out_ready = (ready_mode == 2) ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
  end

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] w [44][4];
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] tmp [4];
    logic [7:0] rc, x;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) w[i][j] = key[127-8*(4*i+j) -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        x = tmp[0];
        for (int j = 0; j < 3; j++) tmp[j] = sb[tmp[j+1]];
        tmp[3] = sb[x];
        tmp[0] = tmp[0] ^ rc;
        rc = gm(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][r];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++)
        if (rd < 10) s[r][c] = gm(8'h02, t[r][c]) ^ gm(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
        else         s[r][c] = t[r][c];
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[4*rd+c][r];
    end
    for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Output monitor: every consumed block must be the next expected one.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_output: got %h, expected none", out_data);
      end else chk("out_data", out_data, exp_q.pop_front());
    end
  end

  task automatic model_push(input logic [127:0] pt);
    logic [127:0] c;
    case (m_mode)
      2'b01: begin c = ref_aes(m_key, pt ^ m_chain); m_chain = c; end
      2'b10: begin c = ref_aes(m_key, m_chain) ^ pt; m_chain[31:0] = m_chain[31:0] + 32'd1; end
      default: c = ref_aes(m_key, pt);
    endcase
    exp_q.push_back(c);
  endtask

  task automatic do_cfg(input logic [1:0] m, input logic [127:0] k, input logic [127:0] iv, input bit apply);
    @(posedge clk); #1;
    cfg_mode = m; cfg_key = k; cfg_iv = iv; cfg_ld = 1'b1;
    @(posedge clk); #1;
    cfg_ld = 1'b0;
    if (apply) begin m_mode = m; m_key = k; m_chain = iv; end
  endtask

  task automatic send(input logic [127:0] pt, input int budget, input bit use_tbl,
                      input logic [127:0] tbl_ct, output bit ok);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = pt; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (ok) begin
      model_push(pt);
      if (use_tbl) begin void'(exp_q.pop_back()); exp_q.push_back(tbl_ct); end
    end
  endtask

  task automatic wait_idle(input string nm);
    bit f = 1'b0;
    for (int i = 0; i < 400 && !f; i++) begin
      @(negedge clk); f = (exp_q.size() == 0) && !busy && !out_valid;
    end
    n_cmp++;
    if (!f) begin
      n_err++;
      $display("FAIL %s: drain timeout, %0d blocks still expected", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_core(input string nm);
    bit f = 1'b0;
    for (int i = 0; i < 100 && !f; i++) begin @(negedge clk); f = !busy; end
    n_cmp++;
    if (!f) begin n_err++; $display("FAIL %s: busy still 1 after 100 cycles", nm); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit seen;
    logic [127:0] r;
    build_sbox();
    tbl[0] = '{2'b00, KEY_B, 128'h0, PT_B, CT_B};
    tbl[1] = '{2'b00, 128'h000102030405060708090a0b0c0d0e0f, 128'h0,
               128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    tbl[2] = '{2'b10, KEY_B, PT_B, 128'h0, CT_B};
    tbl[3] = '{2'b11, KEY_B, 128'hffff, PT_B, CT_B};
    tbl[4] = '{2'b01, KEY_B, 128'h0, PT_B, CT_B};

    // Reset state, including in_ready staying low in UNCFG with input offered.
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_in_ready", in_ready, 0); chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0); chk("rst_blk_cnt", blk_cnt, 0);
    @(posedge clk); #1; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("uncfg_in_ready", in_ready, 0);
    in_valid = 1'b0;

    // Known-answer table.
    for (int v = 0; v < 5; v++) begin
      do_cfg(tbl[v].mode, tbl[v].key, tbl[v].iv, 1'b1);
      send(tbl[v].pt, 50, 1'b1, tbl[v].ct, ok);
      chk($sformatf("kat%0d_accept", v), ok, 1);
      wait_idle($sformatf("kat%0d", v));
      chk($sformatf("kat%0d_blk_cnt", v), blk_cnt, 1);
    end

    // CBC two-block chaining.
    do_cfg(2'b01, KEY_B, 128'h0, 1'b1);
    send(PT_B, 50, 1'b1, CT_B, ok);
    send(CT_B ^ PT_B, 50, 1'b1, CT_B, ok);
    wait_idle("cbc2");
    chk("cbc2_blk_cnt", blk_cnt, 2);

    // CTR: second block uses counter ...0735, then a low-word wrap case.
    do_cfg(2'b10, KEY_B, PT_B, 1'b1);
    send(128'h0, 50, 1'b1, CT_B, ok);
    send(128'h0, 50, 1'b0, 128'h0, ok);
    wait_idle("ctr_next");
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_cfg(2'b10, r, {r[95:0], 32'hffffffff}, 1'b1);
    for (int i = 0; i < 3; i++) send({$urandom(), $urandom(), $urandom(), $urandom()}, 50, 1'b0, 128'h0, ok);
    wait_idle("ctr_wrap");
    chk("ctr_wrap_blk_cnt", blk_cnt, 3);

    // cfg_ld during WAIT must be ignored (key, mode and blk_cnt all kept).
    do_cfg(2'b00, KEY_B, 128'h0, 1'b1);
    send(PT_B, 50, 1'b1, CT_B, ok);
    chk("wait_busy", busy, 1);
    do_cfg(2'b10, 128'h000102030405060708090a0b0c0d0e0f, 128'h5, 1'b0);
    wait_idle("cfg_in_wait");
    send(PT_B, 50, 1'b1, CT_B, ok);
    wait_idle("cfg_in_wait2");
    chk("cfg_in_wait_blk_cnt", blk_cnt, 2);

    // Back-pressure: four blocks fill the FIFO, the fifth is refused until drained.
    do_cfg(2'b00, {$urandom(), $urandom(), $urandom(), $urandom()}, 128'h0, 1'b1);
    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      send({$urandom(), $urandom(), $urandom(), $urandom()}, 60, 1'b0, 128'h0, ok);
      chk($sformatf("bp_accept%0d", i), ok, 1);
    end
    wait_core("bp_fill");
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    send(r, 20, 1'b0, 128'h0, ok);
    chk("bp_full_refuse", ok, 0);
    chk("bp_full_out_valid", out_valid, 1);
    ready_mode = 1;
    send(r, 60, 1'b0, 128'h0, ok);
    chk("bp_accept4", ok, 1);
    send({$urandom(), $urandom(), $urandom(), $urandom()}, 60, 1'b0, 128'h0, ok);
    chk("bp_accept5", ok, 1);
    wait_idle("bp_drain");
    chk("bp_blk_cnt", blk_cnt, 6);

    // Random streams in every mode with random consumer stalls.
    for (int m = 0; m < 4; m++) begin
      do_cfg(2'(m), {$urandom(), $urandom(), $urandom(), $urandom()},
             {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
      ready_mode = 2;
      for (int i = 0; i < 5; i++) send({$urandom(), $urandom(), $urandom(), $urandom()}, 80, 1'b0, 128'h0, ok);
      ready_mode = 1;
      wait_idle($sformatf("rand_mode%0d", m));
      chk($sformatf("rand_mode%0d_blk_cnt", m), blk_cnt, 5);
    end

    // Asynchronous reset mid-encryption with a block already buffered.
    do_cfg(2'b00, KEY_B, 128'h0, 1'b1);
    ready_mode = 0;
    send(PT_B, 50, 1'b0, 128'h0, ok);
    wait_core("rst_pre");
    send(PT_B, 50, 1'b0, 128'h0, ok);
    @(posedge clk); #1;
    chk("rst_pre_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_in_ready", in_ready, 0); chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0); chk("arst_blk_cnt", blk_cnt, 0);
    exp_q.delete();
    @(posedge clk); #1; rst = 1'b1;
    ready_mode = 1;
    in_valid = 1'b1; in_data = PT_B; seen = 1'b0;
    for (int i = 0; i < 30; i++) begin @(negedge clk); seen = seen | out_valid | in_ready; end
    in_valid = 1'b0;
    chk("post_rst_quiet", seen, 0);
    do_cfg(2'b00, KEY_B, 128'h0, 1'b1);
    send(PT_B, 50, 1'b1, CT_B, ok);
    chk("post_rst_accept", ok, 1);
    wait_idle("post_rst");
    chk("post_rst_blk_cnt", blk_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
